// File: rtl/ram32_fifo_sched.sv
// Stream FIFO built on a single-port 32-entry distributed RAM, with a registered output stage.
// Defining RAM32_FIFO_BYPASS_EN adds a cut-through path into the output stage when the RAM is empty.

module ram32xsp #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [4:0]       addr,
    input  logic [WIDTH-1:0] datai,
    output logic [WIDTH-1:0] datao
);

    logic [WIDTH-1:0] mem_q [32];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= datai;
        end
    end

    assign datao = mem_q[addr];

endmodule

module ram32_fifo_sched #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       level
);

    logic [4:0]       wr_ptr_q, wr_ptr_d;
    logic [4:0]       rd_ptr_q, rd_ptr_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             prio_fetch_q, prio_fetch_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;

    logic             fetch_req;
    logic             wr_ok;
    logic             fetch_gnt;
    logic             wr_gnt;
    logic             bypass;
    logic             ram_we;
    logic [4:0]       ram_addr;
    logic [WIDTH-1:0] ram_rdata;

    assign fetch_req = (cnt_q != 6'd0) & (!out_valid_q | out_ready);
    assign wr_ok     = (cnt_q != 6'd32);
    assign fetch_gnt = fetch_req & (prio_fetch_q | !in_valid | !wr_ok);
    // in_ready must not depend on in_valid, so it only looks at the fetch priority.
    assign in_ready  = wr_ok & !(fetch_req & prio_fetch_q) & !flush;
    assign wr_gnt    = in_valid & in_ready;

`ifdef RAM32_FIFO_BYPASS_EN
    assign bypass = (cnt_q == 6'd0) & (!out_valid_q | out_ready) & wr_gnt;
`else
    assign bypass = 1'b0;
`endif

    assign ram_we   = wr_gnt & !bypass;
    assign ram_addr = ram_we ? wr_ptr_q : rd_ptr_q;

    ram32xsp #(
        .WIDTH (WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .datai (in_data),
        .datao (ram_rdata)
    );

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        cnt_d        = cnt_q;
        prio_fetch_d = prio_fetch_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;

        if (flush) begin
            wr_ptr_d     = 5'd0;
            rd_ptr_d     = 5'd0;
            cnt_d        = 6'd0;
            prio_fetch_d = 1'b1;
            out_valid_d  = 1'b0;
        end else begin
            // Write and fetch are mutually exclusive, so cnt moves by at most one.
            if (ram_we) begin
                wr_ptr_d = wr_ptr_q + 5'd1;
                cnt_d    = cnt_q + 6'd1;
            end
            if (fetch_gnt) begin
                out_data_d  = ram_rdata;
                out_valid_d = 1'b1;
                rd_ptr_d    = rd_ptr_q + 5'd1;
                cnt_d       = cnt_q - 6'd1;
            end else if (bypass) begin
                out_data_d  = in_data;
                out_valid_d = 1'b1;
            end else if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
            if (fetch_req && in_valid && wr_ok) begin
                prio_fetch_d = !prio_fetch_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= 5'd0;
            rd_ptr_q     <= 5'd0;
            cnt_q        <= 6'd0;
            prio_fetch_q <= 1'b1;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            prio_fetch_q <= prio_fetch_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign level     = cnt_q + {5'd0, out_valid_q};

endmodule
